aig_tt_sweep: RTL and testbench
===============================

# aig_tt_sweep

Sequential truth-table sweeper that sits directly upstream of a 4-input single-output AIG netlist. It drives every input minterm in order, waits a programmable settle time, samples the netlist output, and assembles the 16-bit truth table. It then checks the table against an expected table and reports the onset size. This is the stimulus/capture stage used to validate each exact-synthesis netlist in the library against its NPN class representative.

## Interface
Parameters:
- NUM_IN, 4: netlist input count; legal 2..6; TT_W = 2**NUM_IN.
- SETTLE, 1: extra cycles each minterm is held before sampling; legal 0..15.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; honoured only in IDLE.
- exp_tt  in  TT_W  expected truth table; latched on accepted start.
- x  out  NUM_IN  minterm driven to netlist; bit 0 = x0 (LSB).
- y  in  1  netlist output y0.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse; tt/match/ones valid from this cycle.
- tt  out  TT_W  captured table; bit i = y sampled while x == i.
- match  out  1  tt == latched exp_tt.
- ones  out  NUM_IN+1  popcount of tt.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: x = 0, busy = 0. On start = 1: clear tt, latch exp_tt, idx = 0, cnt = SETTLE, go to WAIT.
- WAIT: x = idx. When cnt != 0, decrement cnt. When cnt == 0, write tt[idx] = y. Then:
  - if idx == TT_W-1, go to DONE;
  - otherwise idx++ and reload cnt = SETTLE.
- DONE: done = 1; update match and ones from the final tt; return to IDLE the next cycle.
- start while busy or in DONE: ignored; no queuing.
- Results hold until the next accepted start clears tt. match and ones also hold until that start, then read 0 until the next done.
- idx is NUM_IN bits and never wraps; the sweep terminates on TT_W-1.
- y is assumed combinationally stable within SETTLE+1 cycles of an x change. No synchroniser.

## Timing
- Reset values:
  - state IDLE, busy 0, done 0, x 0;
  - tt 0, match 0, ones 0;
  - latched exp_tt 0, idx 0, cnt 0.
- Reset mid-sweep: immediate return to reset values. No done pulse; no partial tt retained.
- All outputs are registered; x changes only on clock edges.
- Each minterm is held SETTLE+1 cycles and sampled at the last edge of its window.
- With start accepted at edge k:
  - busy is high from k;
  - last sample at edge k + TT_W·(SETTLE+1);
  - done is high for one cycle after that edge, with busy low in the same cycle.
- Defaults: 32 cycles from start to done.
- Back-to-back operation: start asserted during the done cycle is ignored. The earliest accepted start is the cycle after done, when the block is in IDLE.

## Structure
- Package aig_tt_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the default NUM_IN and SETTLE constants;
  - a tt_width function.
- One sub-module, aig_tt_popcount: purely combinational TT_W-bit popcount producing NUM_IN+1 bits. Its output is registered into ones at DONE.
- The netlist under sweep is instantiated by the bench/top, not inside this block.

## Test plan
- AND model (y = x0 & x1), exp_tt 0x8888, SETTLE 1: tt 0x8888, match 1, ones 4, done 32 cycles after start.
- Parity model (y = x0^x1^x2^x3), exp_tt 0x6996, SETTLE 0: tt 0x6996, match 1, ones 8, done 16 cycles after start; x steps 0..15 one value per cycle.
- Constant-1 model, exp_tt 0xFFFE: tt 0xFFFF, match 0, ones 16 (5-bit value 16, no overflow).
- Start pulsed mid-sweep and again during the done cycle: both ignored; a single done pulse; start accepted on the cycle after done.
- rst_n low at sweep cycle 10: all outputs 0 asynchronously; after release, IDLE; a fresh sweep yields the correct table.
- SETTLE 3 with a model whose y lags x by 3 cycles: exact table captured. The same model with SETTLE 1 yields a mismatch (match 0).

Source files
------------

// File: rtl/aig_tt_pkg.sv
// Shared types and defaults for the AIG truth-table sweeper.
// Holds the sweep FSM state encoding and the table-width helper.
package aig_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_IN = 4;
  localparam int DEF_SETTLE = 1;

  function automatic int tt_width(input int num_in);
    return 1 << num_in;
  endfunction

endpackage

// File: rtl/aig_tt_sweep_if.sv
// Sweep control/result bundle between the sweeper and its controller/netlist.
// start is sampled only in IDLE; busy covers the sweep; done pulses one cycle with results valid.
interface aig_tt_sweep_if
  import aig_tt_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN
) ();

  localparam int TT_W = tt_width(NUM_IN);

  logic              start;
  logic [TT_W-1:0]   exp_tt;
  logic [NUM_IN-1:0] x;
  logic              y;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   tt;
  logic              match;
  logic [NUM_IN:0]   ones;
  state_e            dbg_state;

  modport master (
    output start, exp_tt, y,
    input  x, busy, done, tt, match, ones, dbg_state
  );

  modport slave (
    input  start, exp_tt, y,
    output x, busy, done, tt, match, ones, dbg_state
  );

endinterface

// File: rtl/aig_tt_popcount.sv
// Combinational popcount of a captured truth table.
module aig_tt_popcount
  import aig_tt_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  localparam int TT_W = tt_width(NUM_IN)
) (
  input  logic [TT_W-1:0] vec,
  output logic [NUM_IN:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < TT_W; i++) begin
      cnt = cnt + {{NUM_IN{1'b0}}, vec[i]};
    end
  end

endmodule

// File: rtl/aig_tt_sweep.sv
// Truth-table sweeper: walks every minterm, holds each SETTLE+1 cycles,
// samples y at the end of the window, then reports table, match and onset size.
module aig_tt_sweep
  import aig_tt_pkg::*;
#(
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic           clk,
  input  logic           rst_n,
  aig_tt_sweep_if.slave  bus
);

  localparam int TT_W = tt_width(NUM_IN);
  localparam logic [NUM_IN-1:0] IDX_LAST = NUM_IN'(TT_W - 1);
  localparam logic [3:0]        CNT_LOAD = 4'(SETTLE);

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TT_W-1:0]   tt_q, tt_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic              match_q, match_d;
  logic [NUM_IN:0]   ones_q, ones_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NUM_IN-1:0] x_q, x_d;

  logic [TT_W-1:0]   tt_smp;
  logic [NUM_IN:0]   pop_smp;

  // Table as it looks once the current minterm's sample is written; feeds
  // both the capture and the final match/popcount so results land with done.
  always_comb begin
    tt_smp        = tt_q;
    tt_smp[idx_q] = bus.y;
  end

  aig_tt_popcount #(.NUM_IN(NUM_IN)) u_popcount (
    .vec (tt_smp),
    .cnt (pop_smp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    exp_d   = exp_q;
    match_d = match_q;
    ones_d  = ones_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_d     = x_q;

    unique case (state_q)
      ST_IDLE: begin
        x_d    = '0;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = ST_WAIT;
          tt_d    = '0;
          exp_d   = bus.exp_tt;
          idx_d   = '0;
          cnt_d   = CNT_LOAD;
          match_d = 1'b0;
          ones_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tt_d = tt_smp;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            match_d = (tt_smp == exp_q);
            ones_d  = pop_smp;
            x_d     = '0;
          end else begin
            idx_d = idx_q + NUM_IN'(1);
            cnt_d = CNT_LOAD;
            x_d   = idx_q + NUM_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tt_q    <= '0;
      exp_q   <= '0;
      match_q <= 1'b0;
      ones_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      exp_q   <= exp_d;
      match_q <= match_d;
      ones_q  <= ones_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tt        = tt_q;
  assign bus.match     = match_q;
  assign bus.ones      = ones_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_aig_tt_sweep.sv
// Directed bench for aig_tt_sweep: three sweepers (SETTLE 0, 1, 3) each driving
// a selectable behavioural netlist model (AND, parity, constant 1, lagged AND).
module tb_aig_tt_sweep;
  import aig_tt_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model select: 0 AND(x0,x1), 1 parity, 2 constant 1, 3 AND on x delayed 3 cycles
  int mdl0 = 1;
  int mdl1 = 0;
  int mdl3 = 3;

  logic [3:0] l1a = '0, l1b = '0, l1c = '0;
  logic [3:0] l3a = '0, l3b = '0, l3c = '0;

  aig_tt_sweep_if #(.NUM_IN(4)) bus0 ();
  aig_tt_sweep_if #(.NUM_IN(4)) bus1 ();
  aig_tt_sweep_if #(.NUM_IN(4)) bus3 ();

  aig_tt_sweep #(.NUM_IN(4), .SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  aig_tt_sweep #(.NUM_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  aig_tt_sweep #(.NUM_IN(4), .SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  function automatic logic model_y(input int sel, input logic [3:0] xn, input logic [3:0] xl);
    case (sel)
      0:       return xn[0] & xn[1];
      1:       return ^xn;
      2:       return 1'b1;
      3:       return xl[0] & xl[1];
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    l1a <= bus1.x; l1b <= l1a; l1c <= l1b;
    l3a <= bus3.x; l3b <= l3a; l3c <= l3b;
  end

  assign bus0.y = model_y(mdl0, bus0.x, 4'd0);
  assign bus1.y = model_y(mdl1, bus1.x, l1c);
  assign bus3.y = model_y(mdl3, bus3.x, l3c);

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return bus0.done;
      1:       return bus1.done;
      3:       return bus3.done;
      default: return 1'b0;
    endcase
  endfunction

  // Pulses start on one sweeper and returns the number of edges from the
  // accepting edge until done is seen (bounded).
  task automatic sweep(input int sel, input logic [15:0] exp, output int cyc);
    @(posedge clk); #1;
    case (sel)
      0: begin bus0.start = 1'b1; bus0.exp_tt = exp; end
      1: begin bus1.start = 1'b1; bus1.exp_tt = exp; end
      3: begin bus3.start = 1'b1; bus3.exp_tt = exp; end
      default: ;
    endcase
    @(posedge clk); #1;
    bus0.start = 1'b0; bus1.start = 1'b0; bus3.start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done_of(sel) && cyc < 300);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL rst_busy act=%b exp=0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin failures++; $display("FAIL rst_done act=%b exp=0", bus1.done); end
    checks++; if (bus1.x !== 4'd0) begin failures++; $display("FAIL rst_x act=%h exp=0", bus1.x); end
    checks++; if (bus1.tt !== 16'h0) begin failures++; $display("FAIL rst_tt act=%h exp=0", bus1.tt); end
    checks++; if (bus1.match !== 1'b0) begin failures++; $display("FAIL rst_match act=%b exp=0", bus1.match); end
    checks++; if (bus1.ones !== 5'd0) begin failures++; $display("FAIL rst_ones act=%0d exp=0", bus1.ones); end
    checks++; if (bus1.dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state act=%0d exp=%0d", bus1.dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and();
    int cyc;
    mdl1 = 0;
    sweep(1, 16'h8888, cyc);
    checks++; if (cyc !== 32) begin failures++; $display("FAIL and_latency act=%0d exp=32", cyc); end
    checks++; if (bus1.tt !== 16'h8888) begin failures++; $display("FAIL and_tt act=%h exp=8888", bus1.tt); end
    checks++; if (bus1.match !== 1'b1) begin failures++; $display("FAIL and_match act=%b exp=1", bus1.match); end
    checks++; if (bus1.ones !== 5'd4) begin failures++; $display("FAIL and_ones act=%0d exp=4", bus1.ones); end
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL and_busy_at_done act=%b exp=0", bus1.busy); end
    @(posedge clk); #1;
    checks++; if (bus1.done !== 1'b0) begin failures++; $display("FAIL and_done_pulse act=%b exp=0", bus1.done); end
    checks++; if (bus1.tt !== 16'h8888) begin failures++; $display("FAIL and_tt_hold act=%h exp=8888", bus1.tt); end
  endtask

  task automatic test_parity();
    int cyc;
    int xbad;
    mdl0 = 1;
    @(posedge clk); #1;
    bus0.start = 1'b1; bus0.exp_tt = 16'h6996;
    @(posedge clk); #1;
    bus0.start = 1'b0;
    checks++; if (bus0.busy !== 1'b1) begin failures++; $display("FAIL par_busy act=%b exp=1", bus0.busy); end
    xbad = 0;
    if (bus0.x !== 4'd0) xbad++;
    cyc = 0;
    while (!bus0.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!bus0.done && bus0.x !== 4'(cyc)) xbad++;
    end
    checks++; if (cyc !== 16) begin failures++; $display("FAIL par_latency act=%0d exp=16", cyc); end
    checks++; if (xbad !== 0) begin failures++; $display("FAIL par_x_steps act=%0d bad exp=0 bad", xbad); end
    checks++; if (bus0.tt !== 16'h6996) begin failures++; $display("FAIL par_tt act=%h exp=6996", bus0.tt); end
    checks++; if (bus0.match !== 1'b1) begin failures++; $display("FAIL par_match act=%b exp=1", bus0.match); end
    checks++; if (bus0.ones !== 5'd8) begin failures++; $display("FAIL par_ones act=%0d exp=8", bus0.ones); end
  endtask

  task automatic test_const1();
    int cyc;
    mdl1 = 2;
    sweep(1, 16'hFFFE, cyc);
    checks++; if (cyc !== 32) begin failures++; $display("FAIL c1_latency act=%0d exp=32", cyc); end
    checks++; if (bus1.tt !== 16'hFFFF) begin failures++; $display("FAIL c1_tt act=%h exp=ffff", bus1.tt); end
    checks++; if (bus1.match !== 1'b0) begin failures++; $display("FAIL c1_match act=%b exp=0", bus1.match); end
    checks++; if (bus1.ones !== 5'd16) begin failures++; $display("FAIL c1_ones act=%0d exp=16", bus1.ones); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus1.tt !== 16'hFFFF) begin failures++; $display("FAIL c1_tt_hold act=%h exp=ffff", bus1.tt); end
    checks++; if (bus1.ones !== 5'd16) begin failures++; $display("FAIL c1_ones_hold act=%0d exp=16", bus1.ones); end
    bus1.start = 1'b1; bus1.exp_tt = 16'hFFFF;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    checks++; if (bus1.tt !== 16'h0) begin failures++; $display("FAIL c1_tt_clear act=%h exp=0", bus1.tt); end
    checks++; if (bus1.ones !== 5'd0) begin failures++; $display("FAIL c1_ones_clear act=%0d exp=0", bus1.ones); end
    checks++; if (bus1.match !== 1'b0) begin failures++; $display("FAIL c1_match_clear act=%b exp=0", bus1.match); end
    cyc = 0;
    while (!bus1.done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (bus1.match !== 1'b1) begin failures++; $display("FAIL c1_match_second act=%b exp=1", bus1.match); end
  endtask

  task automatic test_start_ignore();
    int cyc;
    mdl1 = 0;
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.exp_tt = 16'h8888;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus1.done) break;
      bus1.start = (cyc == 10);
    end
    checks++; if (cyc !== 32) begin failures++; $display("FAIL ign_mid_latency act=%0d exp=32", cyc); end
    checks++; if (bus1.tt !== 16'h8888) begin failures++; $display("FAIL ign_tt act=%h exp=8888", bus1.tt); end
    bus1.start = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL ign_done_busy act=%b exp=0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin failures++; $display("FAIL ign_done_single act=%b exp=0", bus1.done); end
    checks++; if (bus1.dbg_state !== ST_IDLE) begin failures++; $display("FAIL ign_done_state act=%0d exp=%0d", bus1.dbg_state, ST_IDLE); end
    @(posedge clk); #1;
    bus1.start = 1'b0;
    checks++; if (bus1.busy !== 1'b1) begin failures++; $display("FAIL ign_accept_after act=%b exp=1", bus1.busy); end
    cyc = 0;
    while (!bus1.done && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc !== 32) begin failures++; $display("FAIL ign_second_latency act=%0d exp=32", cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mdl1 = 2;
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.exp_tt = 16'hFFFF;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus1.tt !== 16'h001F) begin failures++; $display("FAIL rm_partial_tt act=%h exp=001f", bus1.tt); end
    checks++; if (bus1.x !== 4'd5) begin failures++; $display("FAIL rm_partial_x act=%h exp=5", bus1.x); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus1.busy !== 1'b0) begin failures++; $display("FAIL rm_busy act=%b exp=0", bus1.busy); end
    checks++; if (bus1.done !== 1'b0) begin failures++; $display("FAIL rm_done act=%b exp=0", bus1.done); end
    checks++; if (bus1.x !== 4'd0) begin failures++; $display("FAIL rm_x act=%h exp=0", bus1.x); end
    checks++; if (bus1.tt !== 16'h0) begin failures++; $display("FAIL rm_tt act=%h exp=0", bus1.tt); end
    checks++; if (bus1.dbg_state !== ST_IDLE) begin failures++; $display("FAIL rm_state act=%0d exp=%0d", bus1.dbg_state, ST_IDLE); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl1 = 0;
    sweep(1, 16'h8888, cyc);
    checks++; if (cyc !== 32) begin failures++; $display("FAIL rm_fresh_latency act=%0d exp=32", cyc); end
    checks++; if (bus1.tt !== 16'h8888) begin failures++; $display("FAIL rm_fresh_tt act=%h exp=8888", bus1.tt); end
    checks++; if (bus1.match !== 1'b1) begin failures++; $display("FAIL rm_fresh_match act=%b exp=1", bus1.match); end
  endtask

  task automatic test_lag();
    int cyc;
    mdl3 = 3;
    sweep(3, 16'h8888, cyc);
    checks++; if (cyc !== 64) begin failures++; $display("FAIL lag3_latency act=%0d exp=64", cyc); end
    checks++; if (bus3.tt !== 16'h8888) begin failures++; $display("FAIL lag3_tt act=%h exp=8888", bus3.tt); end
    checks++; if (bus3.match !== 1'b1) begin failures++; $display("FAIL lag3_match act=%b exp=1", bus3.match); end
    // With a 2-cycle window the 3-cycle lag samples the previous minterm.
    mdl1 = 3;
    sweep(1, 16'h8888, cyc);
    checks++; if (cyc !== 32) begin failures++; $display("FAIL lag1_latency act=%0d exp=32", cyc); end
    checks++; if (bus1.tt !== 16'h1110) begin failures++; $display("FAIL lag1_tt act=%h exp=1110", bus1.tt); end
    checks++; if (bus1.match !== 1'b0) begin failures++; $display("FAIL lag1_match act=%b exp=0", bus1.match); end
    checks++; if (bus1.ones !== 5'd3) begin failures++; $display("FAIL lag1_ones act=%0d exp=3", bus1.ones); end
  endtask

  initial begin
    bus0.start = 1'b0; bus0.exp_tt = '0;
    bus1.start = 1'b0; bus1.exp_tt = '0;
    bus3.start = 1'b0; bus3.exp_tt = '0;
    test_reset();
    test_and();
    test_parity();
    test_const1();
    test_start_ignore();
    test_reset_mid();
    test_lag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
